vid_fetch_sched: RTL and testbench

//   Pixel-fetch scheduler for the video controller. Once enabled and triggered at frame start, it

---
 rtl/vid_fetch_sched.sv | 164 ++++++++++++++++
 tb/tb_vid_fetch_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_fetch_sched.sv
// Pixel-fetch scheduler: walks the framebuffer in 4-beat read bursts, throttled on FIFO room.
// Outputs are registered from the next-state decode, so they line up with the state register.
module vid_fetch_sched #(
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_LEN  = 4,
   parameter int LVL_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             frame_start,
   input  logic [31:0]      base_address,
   input  logic [31:0]      lineinc,
   input  logic [12:0]      hsize,
   input  logic [12:0]      vsize,
   input  logic [LVL_W-1:0] fifo_level,
   input  logic             ackin,
   input  logic [2:0]       cmdin,
   output logic [1:0]       reqout,
   output logic [2:0]       cmdout,
   output logic [1:0]       lenout,
   output logic [31:0]      addrdataout,
   output logic             fifo_write,
   output logic             busy,
   output logic             frame_done,
   output logic             bus_err
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CHECK = 3'd1;
   localparam logic [2:0] BID   = 3'd2;
   localparam logic [2:0] ADDR  = 3'd3;
   localparam logic [2:0] DATA  = 3'd4;

   logic [2:0]  state, nxt_state;
   logic [31:0] fetch_addr, nxt_fetch;
   logic [31:0] line_addr, nxt_line;
   logic [13:0] pix_cnt, nxt_pix;
   logic [12:0] line_cnt, nxt_line_cnt;
   logic [2:0]  beat_cnt, nxt_beat;
   logic [4:0]  wdog, nxt_wdog;
   logic        nxt_err, nxt_done, beat_v;
   logic [LVL_W:0] lvl_sum;
   logic [13:0] pix_sum;
   logic [12:0] lc_inc;
   logic [31:0] line_next;

   assign beat_v    = (state == DATA) && ((cmdin == 3'b011) || (cmdin == 3'b001));
   assign lvl_sum   = {1'b0, fifo_level} + (LVL_W+1)'(BURST_LEN);
   assign pix_sum   = pix_cnt + 14'(BURST_LEN);
   assign lc_inc    = line_cnt + 13'd1;
   assign line_next = line_addr + lineinc;

   always_comb begin
      nxt_state    = state;
      nxt_fetch    = fetch_addr;
      nxt_line     = line_addr;
      nxt_pix      = pix_cnt;
      nxt_line_cnt = line_cnt;
      nxt_beat     = beat_cnt;
      nxt_wdog     = wdog;
      nxt_err      = bus_err;
      nxt_done     = 1'b0;
      case (state)
         IDLE: begin
            if (en && frame_start && (hsize != 13'd0) && (vsize != 13'd0)) begin
               nxt_fetch    = base_address;
               nxt_line     = base_address;
               nxt_pix      = 14'd0;
               nxt_line_cnt = 13'd0;
               nxt_err      = 1'b0;
               nxt_state    = CHECK;
            end
         end
         CHECK: begin
            if (!en)
               nxt_state = IDLE;
            else if (lvl_sum <= (LVL_W+1)'(FIFO_DEPTH))
               nxt_state = BID;
         end
         BID: begin
            if (!en)
               nxt_state = IDLE;
            else if (ackin)
               nxt_state = ADDR;
         end
         ADDR: begin
            nxt_beat  = 3'd0;
            nxt_wdog  = 5'd0;
            nxt_state = DATA;
         end
         DATA: begin
            if (beat_v) begin
               nxt_wdog = 5'd0;
               nxt_beat = beat_cnt + 3'd1;
               if (beat_cnt == 3'(BURST_LEN-1)) begin
                  if (pix_sum >= {1'b0, hsize}) begin
                     // Line end: partial trailing bursts still fetch whole bursts.
                     nxt_line_cnt = lc_inc;
                     nxt_line     = line_next;
                     nxt_fetch    = line_next;
                     nxt_pix      = 14'd0;
                     if (lc_inc == vsize) begin
                        nxt_done  = 1'b1;
                        nxt_state = IDLE;
                     end else begin
                        nxt_state = en ? CHECK : IDLE;
                     end
                  end else begin
                     nxt_fetch = fetch_addr + 32'd16;
                     nxt_pix   = pix_sum;
                     nxt_state = en ? CHECK : IDLE;
                  end
               end
            end else if (wdog == 5'd15) begin
               // Timeout: retry the same burst address from CHECK.
               nxt_err   = 1'b1;
               nxt_wdog  = 5'd0;
               nxt_state = CHECK;
            end else begin
               nxt_wdog = wdog + 5'd1;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         fetch_addr  <= 32'd0;
         line_addr   <= 32'd0;
         pix_cnt     <= 14'd0;
         line_cnt    <= 13'd0;
         beat_cnt    <= 3'd0;
         wdog        <= 5'd0;
         reqout      <= 2'b00;
         cmdout      <= 3'b000;
         lenout      <= 2'b00;
         addrdataout <= 32'd0;
         fifo_write  <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         state       <= nxt_state;
         fetch_addr  <= nxt_fetch;
         line_addr   <= nxt_line;
         pix_cnt     <= nxt_pix;
         line_cnt    <= nxt_line_cnt;
         beat_cnt    <= nxt_beat;
         wdog        <= nxt_wdog;
         reqout      <= (nxt_state == BID)  ? 2'b11  : 2'b00;
         cmdout      <= (nxt_state == ADDR) ? 3'b010 : 3'b000;
         lenout      <= (nxt_state == ADDR) ? 2'b10  : 2'b00;
         addrdataout <= (nxt_state == ADDR) ? nxt_fetch : 32'd0;
         fifo_write  <= beat_v;
         busy        <= (nxt_state != IDLE);
         frame_done  <= nxt_done;
         bus_err     <= nxt_err;
      end
   end

endmodule

// File: tb/tb_vid_fetch_sched.sv
// Directed bench for vid_fetch_sched: per-cycle vector table plus multi-cycle burst sequences.
module tb_vid_fetch_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        en, frame_start, ackin;
   logic [31:0] base_address, lineinc;
   logic [12:0] hsize, vsize;
   logic [4:0]  fifo_level;
   logic [2:0]  cmdin;
   logic [1:0]  reqout, lenout;
   logic [2:0]  cmdout;
   logic [31:0] addrdataout;
   logic        fifo_write, busy, frame_done, bus_err;

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;

   vid_fetch_sched dut (
      .clk(clk), .reset(reset), .en(en), .frame_start(frame_start),
      .base_address(base_address), .lineinc(lineinc), .hsize(hsize), .vsize(vsize),
      .fifo_level(fifo_level), .ackin(ackin), .cmdin(cmdin),
      .reqout(reqout), .cmdout(cmdout), .lenout(lenout), .addrdataout(addrdataout),
      .fifo_write(fifo_write), .busy(busy), .frame_done(frame_done), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (fifo_write === 1'b1 && 0) wr_cnt <= wr_cnt;

   typedef struct {
      logic        en, fs;
      logic [4:0]  lvl;
      logic        ack;
      logic [2:0]  cmd;
      logic [1:0]  req;
      logic [2:0]  cmdo;
      logic [31:0] addr;
      logic        fw, busy, fd;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic cfg(input logic [31:0] b, input logic [31:0] li, input logic [12:0] h, input logic [12:0] v);
      base_address = b; lineinc = li; hsize = h; vsize = v;
   endtask

   task automatic wait_bid(input string nm);
      int n = 0;
      while (reqout !== 2'b11 && n < 40) begin
         tick();
         n++;
      end
      chk({nm, " bid"}, 64'(reqout), 64'(2'b11));
   endtask

   // Grant one cycle after the bid, check the address phase, then feed 4 beats.
   task automatic burst(input string nm, input logic [31:0] exp_addr, input int drop_en_at);
      wait_bid(nm);
      ackin = 1'b1;
      tick();
      ackin = 1'b0;
      chk({nm, " addr"}, 64'({cmdout, lenout, addrdataout, reqout}),
          64'({3'b010, 2'b10, exp_addr, 2'b00}));
      tick();
      for (int b = 0; b < 4; b++) begin
         if (b == drop_en_at) en = 1'b0;
         cmdin = (b % 2 == 1) ? 3'b001 : 3'b011;
         tick();
         cmdin = 3'b000;
         if (fifo_write === 1'b1) wr_cnt++;
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; frame_start = 1'b0; ackin = 1'b0; cmdin = 3'b000;
      fifo_level = 5'd0;
      cfg(32'h0, 32'h0, 13'd0, 13'd0);
      #1;
      chk("reset outputs", 64'({reqout, cmdout, lenout, addrdataout, fifo_write, busy, frame_done, bus_err}), 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      tick();

      // hsize=4, vsize=1: single burst, level throttle 13 -> 12, delayed grant, gap beat
      cfg(32'h2000, 32'h100, 13'd4, 13'd1);
      tbl[0]  = '{1'b1, 1'b1, 5'd0,  1'b0, 3'b000, 2'b00, 3'b000, 32'h0,    1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 5'd13, 1'b0, 3'b000, 2'b00, 3'b000, 32'h0,    1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b000, 2'b11, 3'b000, 32'h0,    1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b000, 2'b11, 3'b000, 32'h0,    1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 5'd12, 1'b1, 3'b000, 2'b00, 3'b010, 32'h2000, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b011, 2'b00, 3'b000, 32'h0,    1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b011, 2'b00, 3'b000, 32'h0,    1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b001, 2'b00, 3'b000, 32'h0,    1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b010, 2'b00, 3'b000, 32'h0,    1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b011, 2'b00, 3'b000, 32'h0,    1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b001, 2'b00, 3'b000, 32'h0,    1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 5'd12, 1'b0, 3'b000, 2'b00, 3'b000, 32'h0,    1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         en = tbl[i].en; frame_start = tbl[i].fs; fifo_level = tbl[i].lvl;
         ackin = tbl[i].ack; cmdin = tbl[i].cmd;
         tick();
         chk($sformatf("vec%0d", i),
             64'({reqout, cmdout, lenout, addrdataout, fifo_write, busy, frame_done, bus_err}),
             64'({tbl[i].req, tbl[i].cmdo, (tbl[i].cmdo == 3'b010) ? 2'b10 : 2'b00,
                  tbl[i].addr, tbl[i].fw, tbl[i].busy, tbl[i].fd, 1'b0}));
      end
      frame_start = 1'b0; ackin = 1'b0; cmdin = 3'b000; fifo_level = 5'd0;

      // 8x2 frame: two bursts per line, line stride 0x100
      cfg(32'h1000, 32'h100, 13'd8, 13'd2);
      wr_cnt = 0;
      start();
      chk("A busy", 64'(busy), 64'd1);
      burst("A0", 32'h1000, -1);
      chk("A0 no done", 64'(frame_done), 64'd0);
      burst("A1", 32'h1010, -1);
      burst("A2", 32'h1100, -1);
      burst("A3", 32'h1110, -1);
      chk("A done", 64'({frame_done, busy}), 64'(2'b10));
      chk("A writes", 64'(wr_cnt), 64'd16);
      tick();
      chk("A done pulse", 64'(frame_done), 64'd0);

      // hsize=6: the second burst overruns the line, next line from line_addr+lineinc
      cfg(32'h4000, 32'h40, 13'd6, 13'd2);
      wr_cnt = 0;
      start();
      burst("C0", 32'h4000, -1);
      burst("C1", 32'h4010, -1);
      burst("C2", 32'h4040, -1);
      burst("C3", 32'h4050, -1);
      chk("C done", 64'({frame_done, busy, wr_cnt[7:0]}), 64'({2'b10, 8'd16}));

      // Data-phase watchdog: 16 idle cycles raise bus_err, same address retried
      cfg(32'h5000, 32'h100, 13'd4, 13'd1);
      start();
      wait_bid("D");
      ackin = 1'b1; tick(); ackin = 1'b0;
      chk("D addr", 64'(addrdataout), 64'h5000);
      tick();
      for (int k = 0; k < 15; k++) tick();
      chk("D 15 idle", 64'({bus_err, busy}), 64'(2'b01));
      tick();
      chk("D timeout", 64'({bus_err, busy}), 64'(2'b11));
      burst("D1", 32'h5000, -1);
      chk("D done sticky", 64'({frame_done, bus_err}), 64'(2'b11));
      start();
      chk("D err clear", 64'({bus_err, busy}), 64'(2'b01));
      en = 1'b0; tick(); en = 1'b1;
      chk("D idle", 64'(busy), 64'd0);

      // en dropped mid-DATA completes burst then idles; en dropped in BID drops bid
      cfg(32'h6000, 32'h100, 13'd8, 13'd1);
      wr_cnt = 0;
      start();
      burst("E0", 32'h6000, 2);
      chk("E idle", 64'({busy, frame_done, wr_cnt[7:0]}), 64'({2'b00, 8'd4}));
      en = 1'b1;
      start();
      wait_bid("E1");
      en = 1'b0;
      tick();
      chk("E drop bid", 64'({reqout, busy}), 64'(3'b000));
      en = 1'b1;

      // Async reset mid-burst, then restart from base_address
      cfg(32'h7000, 32'h100, 13'd8, 13'd1);
      start();
      burst("F0", 32'h7000, -1);
      wait_bid("F1");
      ackin = 1'b1; tick(); ackin = 1'b0;
      chk("F1 addr", 64'(addrdataout), 64'h7010);
      tick();
      cmdin = 3'b011; tick(); cmdin = 3'b000;
      reset = 1'b1;
      #1;
      chk("F reset", 64'({reqout, cmdout, lenout, addrdataout, fifo_write, busy, frame_done, bus_err}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      start();
      burst("F2", 32'h7000, -1);
      burst("F3", 32'h7010, -1);
      chk("F done", 64'({frame_done, busy}), 64'(2'b10));

      // Zero-size frames are ignored
      cfg(32'h8000, 32'h100, 13'd0, 13'd4);
      start();
      chk("G hsize0", 64'(busy), 64'd0);
      cfg(32'h8000, 32'h100, 13'd4, 13'd0);
      start();
      chk("G vsize0", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
